and2_gate_en_seq: RTL and testbench

- Sequencer directly upstream of the 7-track 5 V 2-input AND gate cell.
- Converts an asynchronous enable request into a synchronized, glitch-free enable that drives the gate's A2 pin; the gated signal drives A1.
- Enforces minimum on-time and minimum off-time on the enable.
- Returns a four-phase request/acknowledge handshake to the requester.

---
 rtl/and2_gate_en_seq.sv | 123 ++++++++++++
 tb/tb_and2_gate_en_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/and2_gate_en_seq.sv
// Enable sequencer feeding A2 of a 2-input AND cell: synchronizes a request, enforces
// minimum on/off times and returns a four-phase ACK. Define AND2_GATE_EN_SEQ_GRANT_CNT_EN for grant_cnt.
module and2_gate_en_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_ON_CYC  = 4,
  parameter int MIN_OFF_CYC = 4,
  parameter int CW          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  output logic       en,
  output logic       ack,
  output logic       busy,
`ifdef AND2_GATE_EN_SEQ_GRANT_CNT_EN
  output logic [7:0] grant_cnt,
`endif
  inout  wire        vdd,
  inout  wire        vss
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_ON_HOLD  = 2'd1,
    ST_ON       = 2'd2,
    ST_OFF_HOLD = 2'd3
  } seqState_e;

  localparam logic [CW-1:0] ON_LOAD  = CW'(MIN_ON_CYC - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(MIN_OFF_CYC - 1);

  logic [SYNC_STAGES-1:0] syncFf;
  logic                   reqS;
  seqState_e              state;
  seqState_e              stateNext;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cntNext;
  logic                   enNext;
  logic                   busyNext;

  assign reqS = syncFf[SYNC_STAGES-1];
  assign ack  = en;

  // State register; en/busy are registered copies of the next-state decode so that
  // the AND gate pin is driven straight from a flop and can never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      syncFf <= '0;
      state  <= ST_OFF;
      cnt    <= '0;
      en     <= 1'b0;
      busy   <= 1'b0;
    end else begin
      syncFf <= {syncFf[SYNC_STAGES-2:0], req};
      state  <= stateNext;
      cnt    <= cntNext;
      en     <= enNext;
      busy   <= busyNext;
    end
  end

  // Holds only act on req_s once the counter has drained, so requests seen mid-hold
  // are deferred rather than lost; the counter only ever counts down to zero.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      ST_OFF: begin
        if (reqS) begin
          stateNext = ST_ON_HOLD;
          cntNext   = ON_LOAD;
        end
      end
      ST_ON_HOLD: begin
        if (cnt != '0) begin
          cntNext = cnt - CW'(1);
        end else if (reqS) begin
          stateNext = ST_ON;
        end else begin
          stateNext = ST_OFF_HOLD;
          cntNext   = OFF_LOAD;
        end
      end
      ST_ON: begin
        if (!reqS) begin
          stateNext = ST_OFF_HOLD;
          cntNext   = OFF_LOAD;
        end
      end
      ST_OFF_HOLD: begin
        if (cnt != '0) begin
          cntNext = cnt - CW'(1);
        end else if (reqS) begin
          stateNext = ST_ON_HOLD;
          cntNext   = ON_LOAD;
        end else begin
          stateNext = ST_OFF;
        end
      end
      default: begin
        stateNext = ST_OFF;
        cntNext   = '0;
      end
    endcase
  end

  always_comb begin
    enNext   = (stateNext == ST_ON_HOLD) || (stateNext == ST_ON);
    busyNext = (stateNext == ST_ON_HOLD) || (stateNext == ST_OFF_HOLD);
  end

`ifdef AND2_GATE_EN_SEQ_GRANT_CNT_EN
  // Every entry into ON_HOLD is a new grant; ON never re-enters ON_HOLD directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= 8'd0;
    end else if ((stateNext == ST_ON_HOLD) && (state != ST_ON_HOLD) && (grant_cnt != 8'hFF)) begin
      grant_cnt <= grant_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_and2_gate_en_seq.sv
// Scoreboard bench for and2_gate_en_seq: directed per-cycle vectors push expected en/busy,
// a negedge monitor pops and compares. Grant counter checked when its macro is defined.
module tb_and2_gate_en_seq;

  typedef struct {
    logic en;
    logic busy;
    int   vec;
  } expect_t;

  logic clk;
  logic rst;
  logic req;
  logic en;
  logic ack;
  logic busy;
  wire  vdd = 1'b1;
  wire  vss = 1'b0;
`ifdef AND2_GATE_EN_SEQ_GRANT_CNT_EN
  logic [7:0] grantCnt;
`endif

  expect_t expQ[$];
  int      errors = 0;
  int      checks = 0;
  int      vecNo  = 0;

  and2_gate_en_seq dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .en        (en),
    .ack       (ack),
    .busy      (busy),
`ifdef AND2_GATE_EN_SEQ_GRANT_CNT_EN
    .grant_cnt (grantCnt),
`endif
    .vdd       (vdd),
    .vss       (vss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs n times; expected outputs are those after each edge.
  task automatic applyStimulus(input logic r, input logic q, input int n,
                               input logic expEn, input logic expBusy);
    for (int i = 0; i < n; i++) begin
      expect_t e;
      rst    = r;
      req    = q;
      e.en   = expEn;
      e.busy = expBusy;
      e.vec  = vecNo;
      expQ.push_back(e);
      vecNo++;
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: one DUT output sample per cycle, compared against the oldest expectation.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      expect_t e;
      e = expQ.pop_front();
      checkOutput($sformatf("vec%0d en/ack/busy", e.vec),
                  int'({en, ack, busy}), int'({e.en, e.en, e.busy}));
    end
  end

  initial begin
    rst = 1'b1;
    req = 1'b1;

    // Reset held with req high, then release: en after the third edge.
    applyStimulus(1, 1, 3, 0, 0);
    applyStimulus(0, 1, 2, 0, 0);
    applyStimulus(0, 1, 4, 1, 1);
    applyStimulus(0, 1, 4, 1, 0);

    // Request drop: two edges of latency, four cycles of off-hold, then idle.
    applyStimulus(0, 0, 2, 1, 0);
    applyStimulus(0, 0, 4, 0, 1);
    applyStimulus(0, 0, 3, 0, 0);

    // Single-cycle pulse stretched to the minimum on and off times.
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 4, 1, 1);
    applyStimulus(0, 0, 4, 0, 1);
    applyStimulus(0, 0, 2, 0, 0);

    // Request dips inside ON_HOLD but is high again at expiry: en never drops.
    applyStimulus(0, 1, 2, 0, 0);
    applyStimulus(0, 0, 1, 1, 1);
    applyStimulus(0, 1, 3, 1, 1);
    applyStimulus(0, 1, 3, 1, 0);

    // Request returns inside OFF_HOLD: en stays low until the hold expires.
    applyStimulus(0, 0, 2, 1, 0);
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 1, 3, 0, 1);
    applyStimulus(0, 1, 4, 1, 1);
    applyStimulus(0, 1, 2, 1, 0);

    // Back to OFF, re-enter ON_HOLD, reset when cnt=2, then resynchronize.
    applyStimulus(0, 0, 2, 1, 0);
    applyStimulus(0, 0, 4, 0, 1);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 1, 2, 0, 0);
    applyStimulus(0, 1, 2, 1, 1);
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(0, 1, 2, 0, 0);
    applyStimulus(0, 1, 4, 1, 1);
    applyStimulus(0, 1, 2, 1, 0);

    @(negedge clk);
    #1;
    checkOutput("scoreboard drained", expQ.size(), 0);

`ifdef AND2_GATE_EN_SEQ_GRANT_CNT_EN
    // 10-high/10-low periods each yield exactly one grant; count saturates at 255.
    rst = 1'b1;
    req = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("grant after reset", int'(grantCnt), 0);
    rst = 1'b0;
    for (int p = 0; p < 300; p++) begin
      req = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      req = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checkOutput($sformatf("grant period %0d", p), int'(grantCnt), (p + 1 > 255) ? 255 : p + 1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("grant cleared by reset", int'(grantCnt), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
